mov_tick_sched: RTL
===================

# mov_tick_sched

Shared movement-tick scheduler for the game datapath. Generates a programmable movement tick from the system clock and hands each tick to exactly one requesting mover (sprite, player or spinner) using round-robin arbitration. Movers issue level requests and receive a one-cycle step pulse. The divisor is reconfigurable at run time through a valid/ready handshake.

## Interface
Parameters:
- `N_MOVERS`, 4: number of requesters (2..16).
- `CNT_W`, 32: divisor and counter width.
- `DIV_DEFAULT`, 50: divisor loaded at reset. Tick period is divisor+1 cycles.

Ports (reset is synchronous and active-low):
- `clkIn` in 1: system clock; all logic on its rising edge.
- `reset` in 1: reset, synchronous, active-low.
- `cfg_valid` in 1: new divisor offered.
- `cfg_div` in CNT_W: divisor value; 0 is legal and gives a tick every cycle.
- `cfg_ready` out 1: block can accept a divisor.
- `req` in N_MOVERS: level request per mover.
- `step` out N_MOVERS: one-hot grant pulse, one cycle wide.
- `tick` out 1: one-cycle pulse per movement tick, granted or not.
- `defer_cnt` out 8: saturating count of ticks on which more than one request was pending.
- `pause` in 1: present only with `MOV_SCHED_PAUSE_EN`.

## Operation
- States are RUN and LOAD. Reset enters RUN.
- Reset values:
  - `counter` = 0, `divisor` = DIV_DEFAULT, round-robin pointer `last` = N_MOVERS-1.
  - Outputs: `tick` = 0, `step` = 0, `defer_cnt` = 0, `cfg_ready` = 1.
- RUN:
  - If counter == divisor: counter <= 0, tick event. Otherwise counter <= counter+1.
  - `cfg_ready` = 1 in RUN and 0 in LOAD (combinational from state).
  - cfg_valid && cfg_ready accepted: divisor_next <= cfg_div, go to LOAD.
- LOAD (one cycle): divisor <= divisor_next, counter <= 0, no tick event, return to RUN.
- Tick event, evaluated on the cycle counter == divisor in RUN:
  - Search `req` starting at index last+1, wrapping at N_MOVERS.
  - If a requester is found, grant the first one and set last <= granted index.
  - If `req` == 0: no grant and `last` unchanged; `tick` still pulses.
  - popcount(req) >= 2: defer_cnt <= defer_cnt+1, saturating at 255.
- Cfg accept on the same cycle as a tick event: the tick and grant are still issued with the old divisor, then LOAD follows.
- Counter comparison is equality only. The counter never exceeds the divisor because LOAD zeroes it.
- A reset asserted mid-operation (sampled at the clock edge) restores all reset values on the next edge. A pending cfg is discarded.

## Timing
- `tick` and `step` are registered and assert in the cycle after counter == divisor.
- `req` is sampled only in the counter == divisor cycle. A request dropped before that cycle is not granted.
- Steady-state tick spacing is divisor+1 cycles.
- After a cfg accept at cycle t: LOAD occupies t+1. The counter is 0 at t+2 with the new divisor, and the first new tick asserts at t+2+cfg_div+1.
- `step` is always one-hot or zero, and step != 0 implies tick == 1.

## Configuration
- `MOV_SCHED_PAUSE_EN` defined:
  - `pause` port exists.
  - While pause == 1 in RUN: the counter holds, no tick event occurs, and `tick`/`step` stay 0.
  - Cfg handshake still works; LOAD still zeroes the counter.
- `MOV_SCHED_PAUSE_EN` undefined: no `pause` port, and the counter runs unconditionally.

## Structure
- Shared package `mov_pkg` holds:
  - The state enum (RUN, LOAD).
  - The DIV_DEFAULT constant.
  - The defer counter width (8).
- Sub-module `mov_rr_arb`: combinational round-robin arbiter taking (req, last) and producing one-hot grant and index.
- The top level owns the counter, the FSM, pointer/grant registering and `defer_cnt`.

## Test plan
- Reset defaults, req=0: with DIV_DEFAULT=50, tick pulses every 51 cycles and step stays 0.
- req=4'b1111, divisor 3: step sequence 0001, 0010, 0100, 1000, 0001 on successive ticks 4 cycles apart; defer_cnt increments each tick.
- req=4'b0100 only: every tick grants 0100, defer_cnt stays 0. Then req=4'b1100: next grant is 1000, then 0100.
- Reprogram to cfg_div=0 on the tick cycle:
  - That tick is still granted.
  - cfg_ready is 0 for one cycle.
  - Afterwards tick is high every cycle.
- Saturation and reset: 300 contended ticks leave defer_cnt at 255. Reset low for one cycle mid-count returns all outputs to their reset values, and the next tick follows 51 cycles later.
- With MOV_SCHED_PAUSE_EN, pause=1 for 20 cycles mid-period: the tick is delayed by exactly 20 cycles and no step pulses occur during the pause.

Source files
------------

// File: rtl/mov_pkg.sv
// rtl/mov_pkg.sv - shared types and constants for the movement-tick scheduler
// Purpose : state encoding, reset divisor and defer counter width used by
//           mov_tick_sched, its interface and the bench.
// Ports   : none (package).
package mov_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_LOAD = 1'b1
   } state_t;

   localparam int MOV_DIV_DEFAULT = 50;
   localparam int DEFER_W         = 8;

endpackage

// File: rtl/mov_tick_sched_if.sv
// rtl/mov_tick_sched_if.sv - divisor config handshake and mover request/step bundle
// Purpose : groups the cfg valid/ready handshake, the per-mover request/step
//           vectors, the tick pulse and the defer counter.
// Ports   : master - drives cfg_valid, cfg_div, req; observes the rest.
//           slave  - the scheduler side (drives cfg_ready, step, tick, defer_cnt).
interface mov_tick_sched_if #(
   parameter int N_MOVERS = 4,
   parameter int CNT_W    = 32
);
   import mov_pkg::*;

   logic                cfg_valid;
   logic [CNT_W-1:0]    cfg_div;
   logic                cfg_ready;
   logic [N_MOVERS-1:0] req;
   logic [N_MOVERS-1:0] step;
   logic                tick;
   logic [DEFER_W-1:0]  defer_cnt;

   modport master (
      output cfg_valid, cfg_div, req,
      input  cfg_ready, step, tick, defer_cnt
   );

   modport slave (
      input  cfg_valid, cfg_div, req,
      output cfg_ready, step, tick, defer_cnt
   );

endinterface

// File: rtl/mov_rr_arb.sv
// rtl/mov_rr_arb.sv - combinational round-robin arbiter
// Purpose : picks the first asserted request at or after index last+1,
//           wrapping at N.
// Ports   : req   in  N     - request vector
//           last  in  IDX_W - most recently granted index
//           grant out N     - one-hot grant (zero when req == 0)
//           idx   out IDX_W - index of the granted requester
//           found out 1     - a requester was granted
module mov_rr_arb #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      int p;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      p     = 0;
      // Offsets 1..N visit every requester once, ending on last itself.
      for (int k = 1; k <= N; k++) begin
         p = (int'(last) + k) % N;
         if (!found && req[p]) begin
            found    = 1'b1;
            grant[p] = 1'b1;
            idx      = IDX_W'(p);
         end
      end
   end

endmodule

// File: rtl/mov_tick_sched.sv
// rtl/mov_tick_sched.sv - programmable movement tick with round-robin step grant
// Purpose : divides clkIn to a tick every divisor+1 cycles and hands each tick
//           to one requesting mover; divisor reloadable via cfg handshake.
// Ports   : clkIn in  1 - clock, rising edge
//           reset in  1 - synchronous, active-low
//           pause in  1 - only when MOV_SCHED_PAUSE_EN is defined; freezes the counter
//           bus   slave - cfg_valid/cfg_div/cfg_ready, req/step, tick, defer_cnt
// Build   : MOV_SCHED_PAUSE_EN adds the pause input.
module mov_tick_sched
   import mov_pkg::*;
#(
   parameter int N_MOVERS    = 4,
   parameter int CNT_W       = 32,
   parameter int DIV_DEFAULT = MOV_DIV_DEFAULT
) (
   input  logic clkIn,
   input  logic reset,
`ifdef MOV_SCHED_PAUSE_EN
   input  logic pause,
`endif
   mov_tick_sched_if.slave bus
);

   localparam int IDX_W = (N_MOVERS > 1) ? $clog2(N_MOVERS) : 1;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    counter_q, counter_d;
   logic [CNT_W-1:0]    divisor_q, divisor_d;
   logic [CNT_W-1:0]    div_next_q, div_next_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic                tick_q, tick_d;
   logic [N_MOVERS-1:0] step_q, step_d;
   logic [DEFER_W-1:0]  defer_q, defer_d;

   logic [N_MOVERS-1:0] grant;
   logic [IDX_W-1:0]    grant_idx;
   logic                grant_found;
   logic                contended;
   logic                run_en;

`ifdef MOV_SCHED_PAUSE_EN
   assign run_en = !pause;
`else
   assign run_en = 1'b1;
`endif

   mov_rr_arb #(
      .N     (N_MOVERS),
      .IDX_W (IDX_W)
   ) u_arb (
      .req   (bus.req),
      .last  (last_q),
      .grant (grant),
      .idx   (grant_idx),
      .found (grant_found)
   );

   assign contended = ($countones(bus.req) >= 2);

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      divisor_d  = divisor_q;
      div_next_d = div_next_q;
      last_d     = last_q;
      tick_d     = 1'b0;
      step_d     = '0;
      defer_d    = defer_q;
      case (state_q)
         ST_RUN: begin
            if (run_en) begin
               if (counter_q == divisor_q) begin
                  counter_d = '0;
                  tick_d    = 1'b1;
                  step_d    = grant;
                  if (grant_found) begin
                     last_d = grant_idx;
                  end
                  if (contended && (defer_q != '1)) begin
                     defer_d = defer_q + DEFER_W'(1);
                  end
               end else begin
                  counter_d = counter_q + CNT_W'(1);
               end
            end
            // A tick on the accept cycle still uses the old divisor;
            // the new one only lands in LOAD.
            if (bus.cfg_valid) begin
               div_next_d = bus.cfg_div;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            divisor_d = div_next_q;
            counter_d = '0;
            state_d   = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clkIn) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         counter_q  <= '0;
         divisor_q  <= CNT_W'(DIV_DEFAULT);
         div_next_q <= CNT_W'(DIV_DEFAULT);
         last_q     <= IDX_W'(N_MOVERS - 1);
         tick_q     <= 1'b0;
         step_q     <= '0;
         defer_q    <= '0;
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         divisor_q  <= divisor_d;
         div_next_q <= div_next_d;
         last_q     <= last_d;
         tick_q     <= tick_d;
         step_q     <= step_d;
         defer_q    <= defer_d;
      end
   end

   assign bus.cfg_ready = (state_q == ST_RUN);
   assign bus.tick      = tick_q;
   assign bus.step      = step_q;
   assign bus.defer_cnt = defer_q;

endmodule
